// File: rtl/ctrl_bundle_pkg.sv
// Shared decode-stage types: the decoded control bundle carried through the
// decode queue, register-address width, and the legal DEPTH range.
package ctrl_bundle_pkg;

  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned CTRL_PAYLOAD_W = 96;
  localparam int unsigned DEPTH_MIN      = 2;
  localparam int unsigned DEPTH_MAX      = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One decoded instruction: register usage for hazard checks plus opaque payload
  typedef struct packed {
    reg_addr_t                 reg_rs1;
    reg_addr_t                 reg_rs2;
    reg_addr_t                 reg_rd;
    logic                      uses_rs1;
    logic                      uses_rs2;
    logic                      wen;
    logic                      halt;
    logic [CTRL_PAYLOAD_W-1:0] payload;
  } ctrl_bundle_t;

  // DEPTH must be a power of two inside [DEPTH_MIN, DEPTH_MAX]
  function automatic logic depth_legal(input int unsigned d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Decode queue handshake bundle.
//   mst : producer/consumer/retire side (drives enq, deq_ready, flush, retire)
//   slv : the queue itself (drives enq_ready, deq_valid, deq_bundle, count, halted)
interface decode_queue_if
  import ctrl_bundle_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             enq_valid;
  logic             enq_ready;
  ctrl_bundle_t     enq_bundle;
  logic             deq_valid;
  logic             deq_ready;
  ctrl_bundle_t     deq_bundle;
  logic             flush;
  logic             retire_valid;
  reg_addr_t        retire_rd;
  logic [CNT_W-1:0] count;
  logic             halted;

  modport mst (
    output enq_valid, enq_bundle, deq_ready, flush, retire_valid, retire_rd,
    input  enq_ready, deq_valid, deq_bundle, count, halted
  );

  modport slv (
    input  enq_valid, enq_bundle, deq_ready, flush, retire_valid, retire_rd,
    output enq_ready, deq_valid, deq_bundle, count, halted
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks registers with an issued-but-unretired write and
// flags a hazard for the queue head.
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_set_valid, i_set_rd      : head issued with a register write
//   i_retire_valid, i_retire_rd: register write completed
//   i_rs1/i_rs2/i_rd, i_uses_* : head register usage to check
//   o_hazard_c                 : head must not issue this cycle (combinational)
module reg_scoreboard
  import ctrl_bundle_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_set_valid,
  input  reg_addr_t i_set_rd,
  input  logic      i_retire_valid,
  input  reg_addr_t i_retire_rd,
  input  reg_addr_t i_rs1,
  input  reg_addr_t i_rs2,
  input  reg_addr_t i_rd,
  input  logic      i_uses_rs1,
  input  logic      i_uses_rs2,
  input  logic      i_wen,
  output logic      o_hazard_c
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_retire_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_pend_eff;
  logic [NUM_REGS-1:0] w_pend_next;

  // One-hot decode of the retiring and newly issued destination registers
  always_comb begin
    w_retire_mask = '0;
    w_set_mask    = '0;
    if (i_retire_valid) w_retire_mask[i_retire_rd] = 1'b1;
    if (i_set_valid)    w_set_mask[i_set_rd]       = 1'b1;
  end

  // A retiring register is already free for this cycle's hazard check
  assign w_pend_eff  = r_pending & ~w_retire_mask;
  // Set is OR'd after the clear so a same-cycle set on the same register wins
  assign w_pend_next = w_pend_eff | w_set_mask;

  assign o_hazard_c = (i_uses_rs1 && (i_rs1 != '0) && w_pend_eff[i_rs1]) ||
                      (i_uses_rs2 && (i_rs2 != '0) && w_pend_eff[i_rs2]) ||
                      (i_wen      && (i_rd  != '0) && w_pend_eff[i_rd]);

  // x0 is never pending
  always_ff @(posedge i_clk) begin
    if (i_rst) r_pending <= '0;
    else       r_pending <= {w_pend_next[NUM_REGS-1:1], 1'b0};
  end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: DEPTH-entry FIFO of decoded bundles between decode and issue,
// with a register scoreboard gating issue of the head and a sticky halt.
//   CLK, RST : clock, synchronous active-high reset
//   q (slv)  : enq/deq handshakes, flush, retire, count, halted
module decode_queue
  import ctrl_bundle_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PAYLOAD_W = CTRL_PAYLOAD_W
) (
  input  logic           CLK,
  input  logic           RST,
  decode_queue_if.slv    q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  if (!depth_legal(DEPTH) || (PAYLOAD_W != CTRL_PAYLOAD_W)) begin : g_bad_param
    $error("decode_queue: DEPTH must be a power of two in range and PAYLOAD_W must match the bundle");
  end

  state_t           r_state;
  ctrl_bundle_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  ctrl_bundle_t     w_head;
  logic             w_halted;
  logic             w_hazard;
  logic             w_not_full;
  logic             w_not_empty;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic             w_set_valid;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_halted    = (r_state == ST_HALTED);
  assign w_not_full  = (r_count < CNT_W'(DEPTH));
  assign w_not_empty = (r_count != '0);

  // Handshakes are held off while reset is asserted
  assign q.enq_ready = !RST && w_not_full && !w_halted && !q.flush;
  assign q.deq_valid = !RST && w_not_empty && !w_hazard && !q.flush && !w_halted;

  assign w_enq_fire  = q.enq_valid && q.enq_ready;
  assign w_deq_fire  = q.deq_valid && q.deq_ready;
  assign w_set_valid = w_deq_fire && w_head.wen && (w_head.reg_rd != '0);

  assign q.deq_bundle = w_head;
  assign q.count      = r_count;
  assign q.halted     = w_halted;

  reg_scoreboard u_scoreboard (
    .i_clk          (CLK),
    .i_rst          (RST),
    .i_set_valid    (w_set_valid),
    .i_set_rd       (w_head.reg_rd),
    .i_retire_valid (q.retire_valid),
    .i_retire_rd    (q.retire_rd),
    .i_rs1          (w_head.reg_rs1),
    .i_rs2          (w_head.reg_rs2),
    .i_rd           (w_head.reg_rd),
    .i_uses_rs1     (w_head.uses_rs1),
    .i_uses_rs2     (w_head.uses_rs2),
    .i_wen          (w_head.wen),
    .o_hazard_c     (w_hazard)
  );

  // Entry storage; no reset needed since count qualifies every read
  always_ff @(posedge CLK) begin
    if (w_enq_fire) r_mem[r_wr_ptr] <= q.enq_bundle;
  end

  // Pointer/occupancy control and RUN/HALTED state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_RUN;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (q.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
          end else begin
            if (w_enq_fire) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq_fire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_enq_fire, w_deq_fire})
              2'b10:   r_count <= r_count + CNT_W'(1);
              2'b01:   r_count <= r_count - CNT_W'(1);
              default: r_count <= r_count;
            endcase
          end
          if (w_deq_fire && w_head.halt) r_state <= ST_HALTED;
        end
        ST_HALTED: begin
          // Queue is frozen until reset
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios followed by a
// randomized phase, all checked against a queue-based behavioural model.
module tb_decode_queue;
  import ctrl_bundle_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH)) dq_if ();

  decode_queue #(.DEPTH(DEPTH), .PAYLOAD_W(CTRL_PAYLOAD_W)) dut (
    .CLK (clk),
    .RST (rst),
    .q   (dq_if.slv)
  );

  // Behavioural model: FIFO contents, pending register set, sticky halt
  ctrl_bundle_t mq[$];
  logic [31:0]  m_pend;
  bit           m_halt;

  int n_vec  = 0;
  int n_miss = 0;

  logic             obs_enq_ready;
  logic             obs_deq_valid;
  logic [CNT_W-1:0] obs_count;
  logic             obs_halted;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_bundle_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic u1, input logic u2,
                                      input logic w, input logic h);
    ctrl_bundle_t b;
    b.reg_rs1  = rs1;
    b.reg_rs2  = rs2;
    b.reg_rd   = rd;
    b.uses_rs1 = u1;
    b.uses_rs2 = u2;
    b.wen      = w;
    b.halt     = h;
    b.payload  = {$urandom(), $urandom(), $urandom()};
    return b;
  endfunction

  function automatic ctrl_bundle_t rnd_bundle();
    return mk(5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
              1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input bit r, input bit ev, input ctrl_bundle_t b, input bit dr,
                      input bit fl, input bit rv, input logic [4:0] rr);
    logic [31:0]  eff;
    ctrl_bundle_t head;
    bit           haz, exp_er, exp_dv, enq_f, deq_f;
    int           sz;
    rst                = r;
    dq_if.enq_valid    = ev;
    dq_if.enq_bundle   = b;
    dq_if.deq_ready    = dr;
    dq_if.flush        = fl;
    dq_if.retire_valid = rv;
    dq_if.retire_rd    = rr;
    #1;
    sz  = mq.size();
    eff = m_pend;
    if (rv) eff[rr] = 1'b0;
    haz  = 1'b0;
    head = '0;
    if (sz > 0) begin
      head = mq[0];
      haz  = (head.uses_rs1 && head.reg_rs1 != 0 && eff[head.reg_rs1]) ||
             (head.uses_rs2 && head.reg_rs2 != 0 && eff[head.reg_rs2]) ||
             (head.wen      && head.reg_rd  != 0 && eff[head.reg_rd]);
    end
    exp_er = !r && (sz < DEPTH) && !m_halt && !fl;
    exp_dv = !r && (sz > 0) && !haz && !fl && !m_halt;

    obs_enq_ready = dq_if.enq_ready;
    obs_deq_valid = dq_if.deq_valid;
    obs_count     = dq_if.count;
    obs_halted    = dq_if.halted;
    check("enq_ready", 128'(obs_enq_ready), 128'(exp_er));
    check("deq_valid", 128'(obs_deq_valid), 128'(exp_dv));
    check("count",     128'(obs_count),     128'(sz));
    check("halted",    128'(obs_halted),    128'(m_halt));
    if (sz > 0) check("deq_bundle", 128'(dq_if.deq_bundle), 128'(head));

    if (r) begin
      mq.delete();
      m_pend = '0;
      m_halt = 1'b0;
    end else begin
      enq_f = ev && exp_er;
      deq_f = dr && exp_dv;
      if (deq_f && head.wen && head.reg_rd != 0) eff[head.reg_rd] = 1'b1;
      m_pend = eff;
      if (fl && !m_halt) mq.delete();
      else begin
        if (deq_f) void'(mq.pop_front());
        if (enq_f) mq.push_back(b);
      end
      if (deq_f && head.halt) m_halt = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit dr);
    step(1'b0, 1'b0, '0, dr, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic enq(input ctrl_bundle_t b, input bit dr);
    step(1'b0, 1'b1, b, dr, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    rst                = 1'b1;
    dq_if.enq_valid    = 1'b0;
    dq_if.enq_bundle   = '0;
    dq_if.deq_ready    = 1'b0;
    dq_if.flush        = 1'b0;
    dq_if.retire_valid = 1'b0;
    dq_if.retire_rd    = '0;
    m_pend             = '0;
    m_halt             = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset: enq_ready low during reset, high the cycle after
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("rst_enq_ready", 128'(obs_enq_ready), 128'(0));
    idle(1'b0);
    check("post_rst_enq_ready", 128'(obs_enq_ready), 128'(1));
    check("post_rst_count", 128'(obs_count), 128'(0));

    // Fill: five back-to-back offers, four accepted
    for (int i = 0; i < 5; i++) enq(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    check("fill_5th_enq_ready", 128'(obs_enq_ready), 128'(0));
    check("fill_count", 128'(obs_count), 128'(4));
    for (int i = 0; i < 4; i++) idle(1'b1);

    // RAW hazard on x5, released by a same-cycle retire
    enq(mk(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
    enq(mk(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("raw_blocked", 128'(obs_deq_valid), 128'(0));
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 5'd5);
    check("raw_release", 128'(obs_deq_valid), 128'(1));

    // Set/retire collision on x7: set wins
    enq(mk(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
    step(1'b0, 1'b1, mk(5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1, 5'd7);
    idle(1'b1);
    check("collision_blocked", 128'(obs_deq_valid), 128'(0));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 5'd7);

    // Flush with three queued and a same-cycle enqueue; x9 stays pending
    enq(mk(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
    idle(1'b1);
    for (int i = 0; i < 3; i++) enq(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    step(1'b0, 1'b1, mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 5'd0);
    check("flush_cycle_count", 128'(obs_count), 128'(3));
    idle(1'b0);
    check("flush_count", 128'(obs_count), 128'(0));
    enq(mk(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    idle(1'b1);
    check("flush_pend_kept", 128'(obs_deq_valid), 128'(0));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 5'd9);

    // Wrap: 12 enqueue/dequeue pairs across three pointer wraps
    for (int i = 0; i < 12; i++)
      enq(mk(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), 5'd0,
             1'b0, 1'b0, 1'($urandom), 1'b0), 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("wrap_drained", 128'(obs_count), 128'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(63, 0) == 0), 1'($urandom_range(3, 0) != 0), rnd_bundle(),
           1'($urandom), 1'($urandom_range(15, 0) == 0), 1'($urandom),
           5'($urandom_range(7, 0)));
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Halt: sticky until reset
    enq(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    enq(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    idle(1'b1);
    for (int i = 0; i < 10; i++) begin
      enq(rnd_bundle(), 1'b1);
      check("halt_halted", 128'(obs_halted), 128'(1));
      check("halt_enq_ready", 128'(obs_enq_ready), 128'(0));
      check("halt_deq_valid", 128'(obs_deq_valid), 128'(0));
      check("halt_count", 128'(obs_count), 128'(1));
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(1'b0);
    check("halt_rst_halted", 128'(obs_halted), 128'(0));
    check("halt_rst_count", 128'(obs_count), 128'(0));
    check("halt_rst_enq_ready", 128'(obs_enq_ready), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
